// File: rtl/ixc_osf_evcap_mc.sv
// Multi-channel edge/event capture: per-channel detect modes, pending records,
// lowest-index arbitration into a timestamped FIFO, sticky vector and overflow flag.
module ixc_osf_evcap_mc #(
    parameter int NCH   = 8,
    parameter int DEPTH = 4,
    parameter int TSW   = 16,
    localparam int CW   = $clog2(NCH)
) (
    input  logic             uclk,
    input  logic             ureset,
    input  logic [NCH-1:0]   pvec,
    input  logic [2*NCH-1:0] mode,
    input  logic             callEmuPre,
    input  logic             ovfClr,
    output logic             osfTbc,
    output logic             evValid,
    input  logic             evReady,
    output logic [CW-1:0]    evChan,
    output logic             evVal,
    output logic [TSW-1:0]   evTs,
    output logic [NCH-1:0]   pvecEvO,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [NCH-1:0] prev;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] pendVal;
    logic [TSW-1:0] pendTs [NCH];
    logic [TSW-1:0] ts;

    logic [CW-1:0]  memChan [DEPTH];
    logic           memVal  [DEPTH];
    logic [TSW-1:0] memTs   [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [AW:0]    count;

    logic [NCH-1:0] ev;
    logic [NCH-1:0] pushVec;
    logic [NCH-1:0] coal;
    logic [CW-1:0]  sel;
    logic           push;
    logic           pop;

    assign evValid = (count != '0);
    assign evChan  = memChan[rdPtr];
    assign evVal   = memVal[rdPtr];
    assign evTs    = memTs[rdPtr];
    assign osfTbc  = (|pend) | evValid;
    assign pop     = evValid & evReady;
    // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
    assign push    = (|pend) & ((count != FULL_COUNT) | pop);

    always_comb begin
        ev      = '0;
        pushVec = '0;
        coal    = '0;
        sel     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i]) sel = CW'(i);
        end
        for (int i = 0; i < NCH; i++) begin
            unique case (mode[2*i +: 2])
                2'b00: ev[i] = 1'b0;
                2'b01: ev[i] = (pvec[i] != prev[i]) & pvec[i];
                2'b10: ev[i] = (pvec[i] != prev[i]) & ~pvec[i];
                default: ev[i] = (pvec[i] != prev[i]);
            endcase
            pushVec[i] = push & (sel == CW'(i));
            coal[i]    = ev[i] & pend[i] & ~pushVec[i];
        end
    end

    always_ff @(posedge uclk) begin
        if (ureset) begin
            prev    <= pvec;
            pend    <= '0;
            pendVal <= '0;
            ts      <= '0;
            pvecEvO <= '0;
            ovf     <= 1'b0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            for (int i = 0; i < NCH; i++) pendTs[i] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                memChan[d] <= '0;
                memVal[d]  <= 1'b0;
                memTs[d]   <= '0;
            end
        end else begin
            prev <= pvec;
            ts   <= ts + 1'b1;
            // A channel being pushed this edge hands over its old record and reloads.
            for (int i = 0; i < NCH; i++) begin
                if (ev[i] && (!pend[i] || pushVec[i])) begin
                    pend[i]    <= 1'b1;
                    pendTs[i]  <= ts;
                    pendVal[i] <= pvec[i];
                end else if (pushVec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            pvecEvO <= ev | (callEmuPre ? '0 : pvecEvO);
            if (|coal)       ovf <= 1'b1;
            else if (ovfClr) ovf <= 1'b0;
            if (push) begin
                memChan[wrPtr] <= sel;
                memVal[wrPtr]  <= pendVal[sel];
                memTs[wrPtr]   <= pendTs[sel];
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ixc_osf_evcap_mc.sv
// Directed self-checking bench for ixc_osf_evcap_mc (default parameters).
module tb_ixc_osf_evcap_mc;

    logic        uclk = 1'b0;
    logic        ureset = 1'b0;
    logic [7:0]  pvec = '0;
    logic [15:0] mode = '0;
    logic        callEmuPre = 1'b0;
    logic        ovfClr = 1'b0;
    logic        osfTbc;
    logic        evValid;
    logic        evReady = 1'b0;
    logic [2:0]  evChan;
    logic        evVal;
    logic [15:0] evTs;
    logic [7:0]  pvecEvO;
    logic        ovf;

    int nCompared = 0;
    int nMismatched = 0;

    ixc_osf_evcap_mc dut (
        .uclk(uclk), .ureset(ureset), .pvec(pvec), .mode(mode),
        .callEmuPre(callEmuPre), .ovfClr(ovfClr), .osfTbc(osfTbc),
        .evValid(evValid), .evReady(evReady), .evChan(evChan), .evVal(evVal),
        .evTs(evTs), .pvecEvO(pvecEvO), .ovf(ovf)
    );

    always #5 uclk = ~uclk;

    task automatic step();
        @(posedge uclk);
        #1;
    endtask

    task automatic resetDut();
        ureset = 1'b1;
        step();
        step();
        ureset = 1'b0;
    endtask

    task automatic test_reset();
        pvec = 8'hA5; mode = 16'hFFFF; evReady = 1'b0;
        resetDut();
        nCompared++;
        if (evValid !== 1'b0 || osfTbc !== 1'b0 || ovf !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got valid=%b tbc=%b ovf=%b expected 0 0 0", evValid, osfTbc, ovf);
        end
        nCompared++;
        if (pvecEvO !== 8'h00 || evChan !== 3'd0 || evTs !== 16'd0 || evVal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data: got ev=%h chan=%0d ts=%0d val=%b expected 0", pvecEvO, evChan, evTs, evVal);
        end
        step();
        nCompared++;
        if (osfTbc !== 1'b0 || pvecEvO !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_nospurious: got tbc=%b ev=%h expected 0 00", osfTbc, pvecEvO);
        end
    endtask

    task automatic test_basic();
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b0;
        resetDut();
        repeat (10) step();
        pvec = 8'h08;
        step();
        nCompared++;
        if (pvecEvO !== 8'h08 || osfTbc !== 1'b1 || evValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL basic_detect: got ev=%h tbc=%b valid=%b expected 08 1 0", pvecEvO, osfTbc, evValid);
        end
        step();
        nCompared++;
        if (evValid !== 1'b1 || evChan !== 3'd3 || evVal !== 1'b1 || evTs !== 16'd10) begin
            nMismatched++;
            $display("[TB] FAIL basic_head: got v=%b chan=%0d val=%b ts=%0d expected 1 3 1 10", evValid, evChan, evVal, evTs);
        end
        step();
        nCompared++;
        if (evValid !== 1'b1 || evTs !== 16'd10 || osfTbc !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL basic_hold: got v=%b ts=%0d tbc=%b expected 1 10 1", evValid, evTs, osfTbc);
        end
        evReady = 1'b1;
        step();
        evReady = 1'b0;
        nCompared++;
        if (evValid !== 1'b0 || osfTbc !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL basic_pop: got v=%b tbc=%b expected 0 0", evValid, osfTbc);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] expChan [3];
        expChan[0] = 3'd0; expChan[1] = 3'd5; expChan[2] = 3'd7;
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b1;
        resetDut();
        repeat (3) step();
        pvec = 8'hA1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            nCompared++;
            if (evValid !== 1'b1 || evChan !== expChan[k] || evTs !== 16'd3 || osfTbc !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL b2b_head%0d: got v=%b chan=%0d ts=%0d tbc=%b expected 1 %0d 3 1",
                         k, evValid, evChan, evTs, osfTbc, expChan[k]);
            end
        end
        step();
        nCompared++;
        if (evValid !== 1'b0 || osfTbc !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_drain: got v=%b tbc=%b expected 0 0", evValid, osfTbc);
        end
        evReady = 1'b0;
    endtask

    task automatic test_fifo_full();
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b0;
        resetDut();
        repeat (2) step();
        pvec = 8'h7E;
        step();
        repeat (5) step();
        nCompared++;
        if (evValid !== 1'b1 || evChan !== 3'd1 || osfTbc !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL full_head: got v=%b chan=%0d tbc=%b expected 1 1 1", evValid, evChan, osfTbc);
        end
        for (int k = 1; k <= 6; k++) begin
            nCompared++;
            if (evValid !== 1'b1 || evChan !== 3'(k) || evTs !== 16'd2 || evVal !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL full_drain%0d: got v=%b chan=%0d ts=%0d val=%b expected 1 %0d 2 1",
                         k, evValid, evChan, evTs, evVal, k);
            end
            evReady = 1'b1;
            step();
            evReady = 1'b0;
            step();
        end
        nCompared++;
        if (evValid !== 1'b0 || osfTbc !== 1'b0 || ovf !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL full_end: got v=%b tbc=%b ovf=%b expected 0 0 0", evValid, osfTbc, ovf);
        end
    endtask

    task automatic test_coalesce();
        logic [2:0] expChan [4];
        expChan[0] = 3'd1; expChan[1] = 3'd3; expChan[2] = 3'd4; expChan[3] = 3'd2;
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b0;
        resetDut();
        step();
        pvec = 8'h1B;
        step();
        repeat (4) step();
        pvec = 8'h1F;
        step();
        nCompared++;
        if (ovf !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL coal_first: got ovf=%b expected 0", ovf);
        end
        pvec = 8'h1B;
        step();
        nCompared++;
        if (ovf !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL coal_set: got ovf=%b expected 1", ovf);
        end
        pvec = 8'h1F; ovfClr = 1'b1;
        step();
        nCompared++;
        if (ovf !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL coal_setbeatsclr: got ovf=%b expected 1", ovf);
        end
        step();
        ovfClr = 1'b0;
        nCompared++;
        if (ovf !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL coal_clr: got ovf=%b expected 0", ovf);
        end
        nCompared++;
        if (evValid !== 1'b1 || evChan !== 3'd0 || evTs !== 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL coal_head0: got v=%b chan=%0d ts=%0d expected 1 0 1", evValid, evChan, evTs);
        end
        evReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            nCompared++;
            if (evValid !== 1'b1 || evChan !== expChan[k]) begin
                nMismatched++;
                $display("[TB] FAIL coal_order%0d: got v=%b chan=%0d expected 1 %0d", k, evValid, evChan, expChan[k]);
            end
        end
        nCompared++;
        if (evTs !== 16'd6 || evVal !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL coal_ch2rec: got ts=%0d val=%b expected 6 1", evTs, evVal);
        end
        step();
        nCompared++;
        if (evValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL coal_single: got v=%b expected 0", evValid);
        end
        evReady = 1'b0;
    endtask

    task automatic test_modes();
        pvec = 8'h12; mode = 16'h0204; evReady = 1'b0;
        resetDut();
        pvec = 8'h00;
        step();
        nCompared++;
        if (pvecEvO !== 8'h10) begin
            nMismatched++;
            $display("[TB] FAIL mode_fall: got ev=%h expected 10", pvecEvO);
        end
        step();
        nCompared++;
        if (evValid !== 1'b1 || evChan !== 3'd4 || evVal !== 1'b0 || evTs !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL mode_rec: got v=%b chan=%0d val=%b ts=%0d expected 1 4 0 0", evValid, evChan, evVal, evTs);
        end
        evReady = 1'b1;
        step();
        evReady = 1'b0;
        mode = 16'h0200;
        pvec = 8'h02; step();
        pvec = 8'h00; step();
        pvec = 8'h10; step();
        step();
        nCompared++;
        if (osfTbc !== 1'b0 || evValid !== 1'b0 || pvecEvO !== 8'h10) begin
            nMismatched++;
            $display("[TB] FAIL mode_none: got tbc=%b v=%b ev=%h expected 0 0 10", osfTbc, evValid, pvecEvO);
        end
    endtask

    task automatic test_sticky();
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b1;
        resetDut();
        pvec = 8'h12;
        step();
        nCompared++;
        if (pvecEvO !== 8'h12) begin
            nMismatched++;
            $display("[TB] FAIL sticky_set: got ev=%h expected 12", pvecEvO);
        end
        pvec = 8'h02; callEmuPre = 1'b1;
        step();
        nCompared++;
        if (pvecEvO !== 8'h10) begin
            nMismatched++;
            $display("[TB] FAIL sticky_evbeatsclr: got ev=%h expected 10", pvecEvO);
        end
        step();
        callEmuPre = 1'b0;
        nCompared++;
        if (pvecEvO !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL sticky_clr: got ev=%h expected 00", pvecEvO);
        end
        repeat (4) step();
        evReady = 1'b0;
    endtask

    task automatic test_midreset();
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b0;
        resetDut();
        pvec = 8'h0F;
        step();
        step();
        nCompared++;
        if (osfTbc !== 1'b1 || evValid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midrst_pre: got tbc=%b v=%b expected 1 1", osfTbc, evValid);
        end
        ureset = 1'b1;
        step();
        ureset = 1'b0;
        nCompared++;
        if (osfTbc !== 1'b0 || evValid !== 1'b0 || pvecEvO !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL midrst_clear: got tbc=%b v=%b ev=%h expected 0 0 00", osfTbc, evValid, pvecEvO);
        end
        step();
        nCompared++;
        if (osfTbc !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_after: got tbc=%b expected 0", osfTbc);
        end
    endtask

    task automatic test_wrap();
        pvec = 8'h00; mode = 16'hFFFF; evReady = 1'b0;
        resetDut();
        repeat (65535) step();
        pvec = 8'h40;
        step();
        pvec = 8'hC0;
        step();
        step();
        step();
        nCompared++;
        if (evValid !== 1'b1 || evChan !== 3'd6 || evTs !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL wrap_last: got v=%b chan=%0d ts=%h expected 1 6 ffff", evValid, evChan, evTs);
        end
        evReady = 1'b1;
        step();
        evReady = 1'b0;
        nCompared++;
        if (evValid !== 1'b1 || evChan !== 3'd7 || evTs !== 16'h0000 || evVal !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL wrap_zero: got v=%b chan=%0d ts=%h val=%b expected 1 7 0000 1", evValid, evChan, evTs, evVal);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fifo_full();
        test_coalesce();
        test_modes();
        test_sticky();
        test_midreset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
